// File: rtl/dcfifo_wr_packer.sv
// dcfifo_wr_packer: packs RATIO narrow beats into one wide dual-clock FIFO word
// carrying a lane count and a last flag. It drives the FIFO write port and
// produces an advisory registered almost-full indication.
module dcfifo_wr_packer #(
  parameter int unsigned IN_WIDTH    = 8,
  parameter int unsigned RATIO       = 4,
  parameter int unsigned FIFO_WIDTHU = 3,
  parameter int unsigned AFULL_LEVEL = 6
) (
  input  logic                                         wrclk,
  input  logic                                         wr_rst,
  input  logic [IN_WIDTH-1:0]                          s_data,
  input  logic                                         s_valid,
  input  logic                                         s_last,
  output logic                                         s_ready,
  output logic [RATIO*IN_WIDTH+$clog2(RATIO):0]        fifo_data,
  output logic                                         fifo_wrreq,
  input  logic                                         fifo_wrfull,
  input  logic [FIFO_WIDTHU-1:0]                       fifo_wrusedw,
  output logic                                         almost_full
);

  localparam int unsigned LW        = $clog2(RATIO);
  localparam int unsigned LANES_W   = RATIO * IN_WIDTH;
  localparam int unsigned OUT_WIDTH = LANES_W + LW + 1;

  logic [LANES_W-1:0]   acc_q, acc_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic [OUT_WIDTH-1:0] out_word_q, out_word_d;
  logic                 out_valid_q, out_valid_d;
  logic                 afull_q, afull_d;

  logic                 accept;
  logic                 complete;
  logic                 wr_fire;
  logic [LANES_W-1:0]   merged;

  // A held word stalls the input only while the FIFO reports full
  assign s_ready    = ~wr_rst & (~out_valid_q | ~fifo_wrfull);
  assign fifo_wrreq = out_valid_q & ~fifo_wrfull;
  assign fifo_data  = out_word_q;
  assign almost_full = afull_q;

  // Next-state: merge accepted beat into its lane, close word on last lane or s_last
  always_comb begin
    acc_d       = acc_q;
    lane_d      = lane_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    afull_d     = (32'(fifo_wrusedw) >= 32'(AFULL_LEVEL)) | fifo_wrfull;

    accept   = s_valid & s_ready;
    wr_fire  = out_valid_q & ~fifo_wrfull;
    complete = accept & ((lane_q == LW'(RATIO - 1)) | s_last);

    merged = acc_q;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (lane_q == LW'(i)) begin
        merged[i*IN_WIDTH +: IN_WIDTH] = s_data;
      end
    end

    if (complete) begin
      // Lanes above lane_q stay zero because acc is cleared after every word
      out_word_d  = {s_last, lane_q, merged};
      out_valid_d = 1'b1;
      acc_d       = '0;
      lane_d      = '0;
    end else begin
      if (accept) begin
        acc_d  = merged;
        lane_d = lane_q + LW'(1);
      end
      if (wr_fire) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers; reset discards any partial or held word
  always_ff @(posedge wrclk or posedge wr_rst) begin
    if (wr_rst) begin
      acc_q       <= '0;
      lane_q      <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      afull_q     <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      lane_q      <= lane_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      afull_q     <= afull_d;
    end
  end

endmodule

// File: tb/tb_dcfifo_wr_packer.sv
// Directed bench for dcfifo_wr_packer with default parameters (35-bit FIFO word).
module tb_dcfifo_wr_packer;

  logic        wrclk;
  logic        wr_rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [34:0] fifo_data;
  logic        fifo_wrreq;
  logic        fifo_wrfull;
  logic [2:0]  fifo_wrusedw;
  logic        almost_full;

  int checks;
  int failures;
  int wr_cnt;
  logic [34:0] wr_word;

  dcfifo_wr_packer dut (
    .wrclk        (wrclk),
    .wr_rst       (wr_rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .fifo_data    (fifo_data),
    .fifo_wrreq   (fifo_wrreq),
    .fifo_wrfull  (fifo_wrfull),
    .fifo_wrusedw (fifo_wrusedw),
    .almost_full  (almost_full)
  );

  initial wrclk = 1'b0;
  always #5 wrclk = ~wrclk;

  // Writes are counted at the falling edge, where wrreq is stable for the next rising edge
  initial begin
    wr_cnt  = 0;
    wr_word = '0;
  end
  always @(negedge wrclk) begin
    if (fifo_wrreq === 1'b1) begin
      wr_cnt  = wr_cnt + 1;
      wr_word = fifo_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wrclk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  function automatic logic [63:0] word(input logic l, input logic [1:0] cnt, input logic [31:0] lanes);
    return 64'({l, cnt, lanes});
  endfunction

  int base;
  logic [34:0] held;

  initial begin
    checks       = 0;
    failures     = 0;
    wr_rst       = 1'b1;
    s_data       = '0;
    s_valid      = 1'b0;
    s_last       = 1'b0;
    fifo_wrfull  = 1'b0;
    fifo_wrusedw = '0;
    step();
    step();

    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_wrreq", 64'(fifo_wrreq), 64'd0);
    check("rst_data", 64'(fifo_data), 64'd0);
    check("rst_afull", 64'(almost_full), 64'd0);

    wr_rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(s_ready), 64'd1);
    step();

    // Reset mid-word after two beats
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    wr_rst = 1'b1;
    #1;
    check("midrst_s_ready", 64'(s_ready), 64'd0);
    check("midrst_wrreq", 64'(fifo_wrreq), 64'd0);
    check("midrst_afull", 64'(almost_full), 64'd0);
    step();
    wr_rst = 1'b0;
    step();

    // Full word after reset: no stale lanes
    base = wr_cnt;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    check("full_no_early_wr", 64'(fifo_wrreq), 64'd0);
    send(8'h44, 1'b0);
    check("full_wrreq", 64'(fifo_wrreq), 64'd1);
    check("full_data", 64'(fifo_data), word(1'b0, 2'd3, 32'h44332211));
    step();
    check("full_wrreq_drop", 64'(fifo_wrreq), 64'd0);
    check("full_wr_count", 64'(wr_cnt - base), 64'd1);
    check("full_wr_word", 64'(wr_word), word(1'b0, 2'd3, 32'h44332211));

    // Short packet, then a completing beat on the same edge as the write
    base = wr_cnt;
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    check("short_wrreq", 64'(fifo_wrreq), 64'd1);
    check("short_data", 64'(fifo_data), word(1'b1, 2'd1, 32'h0000BBAA));
    send(8'hCC, 1'b1);
    check("short_next_lane0", 64'(fifo_data), word(1'b1, 2'd0, 32'h000000CC));
    check("short_next_wrreq", 64'(fifo_wrreq), 64'd1);
    step();
    check("short_wr_count", 64'(wr_cnt - base), 64'd2);
    check("short_wr_word", 64'(wr_word), word(1'b1, 2'd0, 32'h000000CC));

    // Last on the final lane
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b1);
    check("lastfull_data", 64'(fifo_data), word(1'b1, 2'd3, 32'h04030201));
    step();
    check("lastfull_wr_word", 64'(wr_word), word(1'b1, 2'd3, 32'h04030201));

    // Backpressure with a held word and a pending non-completing beat
    base = wr_cnt;
    send(8'hD1, 1'b0);
    send(8'hD2, 1'b0);
    send(8'hD3, 1'b0);
    send(8'hD4, 1'b0);
    fifo_wrfull = 1'b1;
    s_valid     = 1'b1;
    s_data      = 8'hE1;
    #1;
    held = fifo_data;
    check("bp_held_word", 64'(held), word(1'b0, 2'd3, 32'hD4D3D2D1));
    for (int i = 0; i < 10; i++) begin
      check("bp_wrreq", 64'(fifo_wrreq), 64'd0);
      check("bp_s_ready", 64'(s_ready), 64'd0);
      check("bp_data_stable", 64'(fifo_data), 64'(held));
      step();
    end
    check("bp_no_write", 64'(wr_cnt - base), 64'd0);
    fifo_wrfull = 1'b0;
    #1;
    check("bp_release_wrreq", 64'(fifo_wrreq), 64'd1);
    step();
    s_valid = 1'b0;
    check("bp_one_write", 64'(wr_cnt - base), 64'd1);
    check("bp_written_word", 64'(wr_word), word(1'b0, 2'd3, 32'hD4D3D2D1));
    check("bp_ready_after", 64'(s_ready), 64'd1);
    check("bp_wrreq_after", 64'(fifo_wrreq), 64'd0);
    send(8'hE2, 1'b0);
    send(8'hE3, 1'b0);
    send(8'hE4, 1'b0);
    check("bp_next_word", 64'(fifo_data), word(1'b0, 2'd3, 32'hE4E3E2E1));
    step();
    check("bp_total_writes", 64'(wr_cnt - base), 64'd2);

    // Almost-full threshold and wrfull override, one cycle delayed
    fifo_wrusedw = 3'd5;
    step();
    check("af_at5", 64'(almost_full), 64'd0);
    fifo_wrusedw = 3'd6;
    #1;
    check("af_same_cycle", 64'(almost_full), 64'd0);
    step();
    check("af_rise", 64'(almost_full), 64'd1);
    fifo_wrusedw = 3'd5;
    #1;
    check("af_hold", 64'(almost_full), 64'd1);
    step();
    check("af_fall", 64'(almost_full), 64'd0);
    fifo_wrusedw = 3'd0;
    fifo_wrfull  = 1'b1;
    step();
    check("af_wrfull", 64'(almost_full), 64'd1);
    fifo_wrfull = 1'b0;
    step();
    check("af_clear", 64'(almost_full), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
